// File: rtl/ravan_keystream_xor.sv
// XORs a 32-bit stream with a keystream taken from a captured 512-bit key, with one output register stage.
// Latency 1 cycle. in_ready drops whenever the output register is full and stalled, or no key is loaded.
module ravan_keystream_xor #(
  parameter int WORDS_PER_KEY = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [511:0]     hashkey_in,
  input  logic             hashkey_vld,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             key_loaded,
  output logic             rekey_req,
  output logic             key_err,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    EXHAUST = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WPK = CNT_W'(WORDS_PER_KEY);

  state_t             state_q, state_d;
  logic [511:0]       key_q, key_d;
  logic [CNT_W-1:0]   ctr_q, ctr_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               key_err_q, key_err_d;

  logic               accept;
  logic [CNT_W-1:0]   ctr_inc;
  logic [3:0]         idx;
  logic [31:0]        key_word;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    ctr_d       = ctr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    key_err_d   = 1'b0;

    in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
    ctr_inc  = ctr_q + CNT_W'(1);
    idx      = ctr_q[3:0];
    key_word = key_q[{idx, 5'd0} +: 32];

    // Output register drains independently of the state so a word from a prior key is never lost.
    if (accept) begin
      out_data_d  = in_data ^ key_word ^ 32'(ctr_q);
      out_valid_d = 1'b1;
      ctr_d       = ctr_inc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (hashkey_vld) begin
          if (hashkey_in != '0) state_d = LOAD;
          else                  key_err_d = 1'b1;
        end
      end
      LOAD: begin
        key_d   = hashkey_in;
        ctr_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (accept && (ctr_inc == WPK)) state_d = EXHAUST;
      end
      EXHAUST: begin
        if (!hashkey_vld) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      ctr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      ctr_q       <= ctr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      key_err_q   <= key_err_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign key_loaded = (state_q == RUN) || (state_q == EXHAUST);
  assign rekey_req  = (state_q == EXHAUST);
  assign key_err    = key_err_q;
  assign blk_cnt    = ctr_q;

endmodule

// File: tb/tb_ravan_keystream_xor.sv
// Drives two instances (16 and 20 words per key) from shared stimulus; a behavioural model is compared every cycle.
module tb_ravan_keystream_xor;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] hk;
  logic         hv;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         out_ready;

  logic [1:0]   in_rdy_o, out_vld_o, kl_o, rk_o, ke_o;
  logic [31:0]  out_dat_o [2];
  logic [15:0]  blk_o [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ravan_keystream_xor #(.WORDS_PER_KEY(16), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .hashkey_in(hk), .hashkey_vld(hv),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_rdy_o[0]),
    .out_data(out_dat_o[0]), .out_valid(out_vld_o[0]), .out_ready(out_ready),
    .key_loaded(kl_o[0]), .rekey_req(rk_o[0]), .key_err(ke_o[0]), .blk_cnt(blk_o[0])
  );

  ravan_keystream_xor #(.WORDS_PER_KEY(20), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .hashkey_in(hk), .hashkey_vld(hv),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_rdy_o[1]),
    .out_data(out_dat_o[1]), .out_valid(out_vld_o[1]), .out_ready(out_ready),
    .key_loaded(kl_o[1]), .rekey_req(rk_o[1]), .key_err(ke_o[1]), .blk_cnt(blk_o[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 waiting for key, 1 capturing, 2 streaming, 3 spent.
  int          wpk [2] = '{16, 20};
  int          mode [2];
  int unsigned cnt [2];
  bit          ov [2];
  logic [31:0] od [2];
  bit          err [2];
  logic [31:0] mkey [2][16];
  int          p;
  bit          acc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mode[k] = 0; cnt[k] = 0; ov[k] = 0; od[k] = '0; err[k] = 0;
        for (int i = 0; i < 16; i++) mkey[k][i] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        p      = mode[k];
        acc    = (p == 2) && in_valid && (!ov[k] || out_ready);
        err[k] = (p == 0) && hv && (hk == '0);
        if (acc) begin
          od[k] = in_data ^ mkey[k][cnt[k] % 16] ^ cnt[k];
          ov[k] = 1;
          cnt[k]++;
          if (cnt[k] == wpk[k]) mode[k] = 3;
        end else if (out_ready) begin
          ov[k] = 0;
        end
        if (p == 0 && hv && hk != '0) mode[k] = 1;
        if (p == 1) begin
          for (int i = 0; i < 16; i++) mkey[k][i] = hk[i*32 +: 32];
          cnt[k]  = 0;
          mode[k] = 2;
        end
        if (p == 3 && !hv) mode[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m%0d_in_ready", k), {31'd0, in_rdy_o[k]}, {31'd0, (mode[k] == 2) && (!ov[k] || out_ready)});
      chk($sformatf("m%0d_out_valid", k), {31'd0, out_vld_o[k]}, {31'd0, ov[k]});
      chk($sformatf("m%0d_out_data", k), out_dat_o[k], od[k]);
      chk($sformatf("m%0d_key_loaded", k), {31'd0, kl_o[k]}, {31'd0, mode[k] >= 2});
      chk($sformatf("m%0d_rekey_req", k), {31'd0, rk_o[k]}, {31'd0, mode[k] == 3});
      chk($sformatf("m%0d_key_err", k), {31'd0, ke_o[k]}, {31'd0, err[k]});
      chk($sformatf("m%0d_blk_cnt", k), {16'd0, blk_o[k]}, cnt[k]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  initial begin
    rst = 1'b1; hk = '0; hv = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("rst_out_valid", {31'd0, out_vld_o[0]}, 32'd0);
    chk("rst_out_data", out_dat_o[0], 32'd0);
    chk("rst_in_ready", {31'd0, in_rdy_o[0]}, 32'd0);
    chk("rst_key_loaded", {31'd0, kl_o[0]}, 32'd0);
    chk("rst_blk_cnt", {16'd0, blk_o[0]}, 32'd0);

    for (int i = 0; i < 16; i++) hk[i*32 +: 32] = 32'h1000_0000 + i;
    hv = 1'b1;
    cyc(1);
    chk("load_kl_1cyc", {31'd0, kl_o[0]}, 32'd0);
    cyc(1);
    chk("load_kl_2cyc", {31'd0, kl_o[0]}, 32'd1);
    chk("load_in_ready", {31'd0, in_rdy_o[0]}, 32'd1);

    in_valid = 1'b1; in_data = 32'h0;
    for (int w = 0; w < 16; w++) begin
      cyc(1);
      chk("stream_data", out_dat_o[0], 32'h1000_0000);
      chk("stream_cnt", {16'd0, blk_o[0]}, w + 1);
    end
    chk("exh_rekey", {31'd0, rk_o[0]}, 32'd1);
    chk("exh_in_ready", {31'd0, in_rdy_o[0]}, 32'd0);

    in_data = 32'hFFFF_FFFF;
    cyc(1);
    chk("wrap_w16", out_dat_o[1], 32'hEFFF_FFEF);
    chk("wrap_cnt17", {16'd0, blk_o[1]}, 32'd17);
    cyc(1);
    chk("wrap_w17", out_dat_o[1], 32'hEFFF_FFEF);

    out_ready = 1'b0; in_data = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("bp_hold", out_dat_o[1], 32'hEFFF_FFEF);
      chk("bp_in_ready", {31'd0, in_rdy_o[1]}, 32'd0);
    end
    out_ready = 1'b1;
    cyc(1);
    chk("bp_release", out_dat_o[1], 32'h0234_5668);
    chk("bp_cnt", {16'd0, blk_o[1]}, 32'd19);
    in_valid = 1'b0;

    hv = 1'b0;
    cyc(1);
    chk("rekey_idle", {31'd0, rk_o[0]}, 32'd0);
    for (int i = 0; i < 16; i++) hk[i*32 +: 32] = 32'hAAAA_AAAA;
    hv = 1'b1;
    cyc(1);
    chk("rekey_load_kl", {31'd0, kl_o[0]}, 32'd0);
    cyc(1);
    chk("rekey_run_kl", {31'd0, kl_o[0]}, 32'd1);
    chk("rekey_cnt0", {16'd0, blk_o[0]}, 32'd0);
    in_valid = 1'b1; in_data = 32'h0;
    cyc(1);
    chk("rekey_data", out_dat_o[0], 32'hAAAA_AAAA);
    in_valid = 1'b0; out_ready = 1'b0;
    cyc(1);
    #1;
    chk("pre_rst_valid", {31'd0, out_vld_o[0]}, 32'd1);
    rst = 1'b1;
    #2;
    chk("arst_valid", {31'd0, out_vld_o[0]}, 32'd0);
    chk("arst_kl", {31'd0, kl_o[0]}, 32'd0);
    chk("arst_cnt", {16'd0, blk_o[0]}, 32'd0);

    hk = '0; hv = 1'b1; out_ready = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("zkey_err1", {31'd0, ke_o[0]}, 32'd1);
    cyc(1);
    chk("zkey_err2", {31'd0, ke_o[0]}, 32'd1);
    chk("zkey_kl", {31'd0, kl_o[0]}, 32'd0);
    hv = 1'b0;
    cyc(1);
    chk("zkey_clear", {31'd0, ke_o[0]}, 32'd0);
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
